// File: rtl/aes_word_loader.sv
// Word-serial loader around a combinational AES-128 encryption core.
// Collects four 32-bit key words and four plaintext words (most significant
// word first), holds the assembled 128-bit operands stable while the core
// settles, captures the ciphertext and streams it back as four words.
// Valid/ready handshakes are used on both the input and the output side.

module aes_word_loader #(
    parameter int SETTLE_CYCLES = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_word,
    input  logic          in_is_key,
    output logic [127:0]  aes_keyin,
    output logic [127:0]  aes_statein,
    input  logic [127:0]  aes_stateout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_word,
    output logic          key_valid,
    output logic          busy
);

    // Settle counter only needs to reach SETTLE_CYCLES-1; keep it at least 1 bit wide.
    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          key_cnt_q, key_cnt_d;
    logic [1:0]          data_cnt_q, data_cnt_d;
    logic [1:0]          out_cnt_q, out_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [127:0]        key_reg_q, key_reg_d;
    logic [127:0]        data_reg_q, data_reg_d;
    logic [127:0]        result_q, result_d;
    logic                key_valid_q, key_valid_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_word_q, out_word_d;

    // Word slot k of a 128-bit group occupies bits [127-32k -: 32].
    function automatic logic [127:0] put_word(input logic [127:0] vec,
                                              input logic [1:0]   idx,
                                              input logic [31:0]  w);
        logic [127:0] r;
        r = vec;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] get_word(input logic [127:0] vec,
                                             input logic [1:0]   idx);
        logic [31:0] r;
        case (idx)
            2'd0:    r = vec[127:96];
            2'd1:    r = vec[95:64];
            2'd2:    r = vec[63:32];
            default: r = vec[31:0];
        endcase
        return r;
    endfunction

    // Next-state logic: word assembly in LOAD, settle timing in WAIT, word streaming in OUT.
    always_comb begin
        state_d     = state_q;
        key_cnt_d   = key_cnt_q;
        data_cnt_d  = data_cnt_q;
        out_cnt_d   = out_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        key_reg_d   = key_reg_q;
        data_reg_d  = data_reg_q;
        result_d    = result_q;
        key_valid_d = key_valid_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        in_ready    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // Plaintext is only taken once a complete key is present and no
                // key reload is half-way through.
                in_ready = in_is_key ? 1'b1 : (key_valid_q && (key_cnt_q == 2'd0));
                if (in_valid && in_ready) begin
                    if (in_is_key) begin
                        key_reg_d = put_word(key_reg_q, key_cnt_q, in_word);
                        key_cnt_d = key_cnt_q + 2'd1;
                        if (key_cnt_q == 2'd3) begin
                            key_valid_d = 1'b1;
                        end else if (key_cnt_q == 2'd0) begin
                            key_valid_d = 1'b0;
                        end
                    end else begin
                        data_reg_d = put_word(data_reg_q, data_cnt_q, in_word);
                        if (data_cnt_q == 2'd3) begin
                            data_cnt_d = 2'd0;
                            wait_cnt_d = '0;
                            state_d    = ST_WAIT;
                        end else begin
                            data_cnt_d = data_cnt_q + 2'd1;
                        end
                    end
                end
            end

            ST_WAIT: begin
                // Operands stay frozen here; the core is a multicycle path.
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_cnt_q == WAIT_LAST) begin
                    result_d    = aes_stateout;
                    out_cnt_d   = 2'd0;
                    out_valid_d = 1'b1;
                    out_word_d  = aes_stateout[127:96];
                    state_d     = ST_OUT;
                end
            end

            ST_OUT: begin
                // out_valid is always high in this state; load the next word on transfer.
                if (out_ready) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_LOAD;
                    end else begin
                        out_word_d = get_word(result_q, out_cnt_q + 2'd1);
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State register with synchronous reset discarding any partial key, data or output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            key_cnt_q   <= 2'd0;
            data_cnt_q  <= 2'd0;
            out_cnt_q   <= 2'd0;
            wait_cnt_q  <= '0;
            key_reg_q   <= '0;
            data_reg_q  <= '0;
            result_q    <= '0;
            key_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_cnt_q   <= key_cnt_d;
            data_cnt_q  <= data_cnt_d;
            out_cnt_q   <= out_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            key_reg_q   <= key_reg_d;
            data_reg_q  <= data_reg_d;
            result_q    <= result_d;
            key_valid_q <= key_valid_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
        end
    end

    assign aes_keyin   = key_reg_q;
    assign aes_statein = data_reg_q;
    assign out_valid   = out_valid_q;
    assign out_word    = out_word_q;
    assign key_valid   = key_valid_q;
    assign busy        = (state_q != ST_LOAD);

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader. A behavioural stand-in for the
// combinational AES core returns known-answer ciphertexts only once its
// inputs have been stable long enough; a scoreboard holds expected words.

module tb_aes_word_loader;

    localparam int SETTLE = 12;
    localparam int BOUND  = 200;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] KEY_2  = 128'hfeedface_cafebabe_01234567_89abcdef;
    localparam logic [127:0] PT_2   = 128'h11111111_22222222_33333333_44444444;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_word;
    logic          in_is_key;
    logic [127:0]  aes_keyin;
    logic [127:0]  aes_statein;
    logic [127:0]  aes_stateout;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_word;
    logic          key_valid;
    logic          busy;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int lastDataEdge = 0;
    bit latArmed    = 0;

    logic [31:0]  sb[$];
    logic [127:0] tbKey;
    logic [127:0] tbPt;
    int           tbKcnt;
    int           tbDcnt;

    aes_word_loader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .in_is_key    (in_is_key),
        .aes_keyin    (aes_keyin),
        .aes_statein  (aes_statein),
        .aes_stateout (aes_stateout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .key_valid    (key_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Known-answer table for the vectors used; anything else gets a scrambled mix.
    function automatic logic [127:0] coreFunc(input logic [127:0] k, input logic [127:0] p);
        if (k == KEY_C1 && p == PT_C1) return CT_C1;
        if (k == '0 && p == '0)        return CT_Z;
        return {p[95:0], p[127:96]} ^ k ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    endfunction

    function automatic logic [31:0] wordOf(input logic [127:0] v, input int k);
        return v[127 - 32*k -: 32];
    endfunction

    // Core stand-in: output is garbage until inputs have been held for SETTLE-1 negedges.
    logic [255:0] corePrev;
    int           coreStable = 0;
    always @(negedge clk) begin
        if ({aes_keyin, aes_statein} !== corePrev) begin
            corePrev   = {aes_keyin, aes_statein};
            coreStable = 0;
        end else if (coreStable < 1000) begin
            coreStable = coreStable + 1;
        end
        aes_stateout = (coreStable >= SETTLE - 1) ? coreFunc(aes_keyin, aes_statein)
                                                  : {4{32'hbad00bad}};
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assertCount = assertCount + 1;
        if (observed !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Output monitor: pops scoreboard on each transfer, checks hold, latency and in_ready.
    bit          prevStall = 0;
    bit          prevOv    = 0;
    logic [31:0] heldWord;
    always @(negedge clk) begin
        if (!rst) begin
            if (prevStall) checkOutput("out_hold", out_word, heldWord);
            if (out_valid && !prevOv && latArmed) begin
                checkOutput("latency", cyc - lastDataEdge, SETTLE);
                latArmed = 0;
            end
            if (out_valid) checkOutput("in_ready_while_out", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("out_unexpected", sb.size(), 1);
                end else begin
                    checkOutput("out_word", out_word, sb.pop_front());
                end
            end
            prevStall = out_valid && !out_ready;
            heldWord  = out_word;
            prevOv    = out_valid;
        end else begin
            prevStall = 0;
            prevOv    = 0;
        end
    end

    // Offer one word and wait (bounded) for acceptance; update the bench model on transfer.
    task automatic applyStimulus(input logic [31:0] w, input logic isKey);
        int n;
        bit ok;
        logic [127:0] ct;
        in_valid  = 1'b1;
        in_word   = w;
        in_is_key = isKey;
        n  = 0;
        ok = 0;
        while (n < BOUND) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            n++;
        end
        if (!ok) begin
            checkOutput("in_accept_timeout", in_ready, 1);
        end else if (isKey) begin
            tbKey[127 - 32*tbKcnt -: 32] = w;
            tbKcnt = (tbKcnt + 1) % 4;
        end else begin
            tbPt[127 - 32*tbDcnt -: 32] = w;
            if (tbDcnt == 3) begin
                ct = coreFunc(tbKey, tbPt);
                for (int k = 0; k < 4; k++) sb.push_back(wordOf(ct, k));
                lastDataEdge = cyc + 1;
                latArmed     = 1;
            end
            tbDcnt = (tbDcnt + 1) % 4;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendWords(input logic [127:0] v, input logic isKey, input int first,
                             input int last);
        for (int k = first; k <= last; k++) applyStimulus(wordOf(v, k), isKey);
    endtask

    // Let the scoreboard drain; optionally toggle out_ready every cycle.
    task automatic drainOutputs(input bit toggle);
        int n;
        out_ready = toggle ? 1'b0 : 1'b1;
        n = 0;
        while (n < BOUND) begin
            @(posedge clk);
            #1;
            if (toggle) out_ready = ~out_ready;
            if (sb.size() == 0 && !out_valid) break;
            n++;
        end
        if (n >= BOUND) checkOutput("drain_timeout", sb.size(), 0);
        out_ready = 1'b1;
        checkOutput("busy_after_block", busy, 0);
    endtask

    task automatic resetDut(input string tag);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_is_key = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        latArmed  = 0;
        tbKey     = '0;
        tbPt      = '0;
        tbKcnt    = 0;
        tbDcnt    = 0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_key_valid"}, key_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_out_word"}, out_word, 0);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        in_is_key = 1'b0;
        out_ready = 1'b1;
        tbKey = '0; tbPt = '0; tbKcnt = 0; tbDcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        resetDut("reset");
        checkOutput("reset_keyin", aes_keyin, 0);
        checkOutput("reset_statein", aes_statein, 0);

        // Data before any key must be refused without disturbing state.
        in_valid  = 1'b1;
        in_is_key = 1'b0;
        in_word   = 32'hdeadbeef;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("nokey_in_ready", in_ready, 0);
        end
        checkOutput("nokey_busy", busy, 0);
        checkOutput("nokey_statein", aes_statein, 0);
        in_valid = 1'b0;
        sendWords(KEY_C1, 1'b1, 0, 3);
        checkOutput("key_valid_loaded", key_valid, 1);
        checkOutput("keyin_loaded", aes_keyin, KEY_C1);
        in_is_key = 1'b0;
        #1;
        checkOutput("data_ready_after_key", in_ready, 1);

        // FIPS-197 C.1, then the same plaintext again on the retained key.
        $display("[TB] C.1 known answer");
        sendWords(PT_C1, 1'b0, 0, 3);
        checkOutput("statein_c1", aes_statein, PT_C1);
        drainOutputs(0);
        sendWords(PT_C1, 1'b0, 0, 3);
        drainOutputs(0);

        // Output backpressure with out_ready toggling every cycle.
        $display("[TB] backpressure");
        sendWords(PT_2, 1'b0, 0, 3);
        drainOutputs(1);

        // Key reload in the middle of a data block.
        $display("[TB] mid-block key reload");
        sendWords(PT_2, 1'b0, 0, 1);
        sendWords(KEY_2, 1'b1, 0, 3);
        sendWords(PT_2, 1'b0, 2, 3);
        drainOutputs(0);

        // Reset while waiting for the core, then a fresh C.1 load.
        $display("[TB] reset in WAIT");
        sendWords(KEY_C1, 1'b1, 0, 3);
        sendWords(PT_C1, 1'b0, 0, 3);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("wait_busy", busy, 1);
        resetDut("rst_wait");
        sendWords(KEY_C1, 1'b1, 0, 3);
        sendWords(PT_C1, 1'b0, 0, 3);
        drainOutputs(0);

        // Reset after two output words were taken.
        $display("[TB] reset in OUT");
        sendWords(PT_C1, 1'b0, 0, 3);
        out_ready = 1'b1;
        n = 0;
        while (n < BOUND && sb.size() > 2) begin
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        checkOutput("out_two_taken", sb.size(), 2);
        resetDut("rst_out");
        sendWords(KEY_C1, 1'b1, 0, 3);
        sendWords(PT_C1, 1'b0, 0, 3);
        drainOutputs(0);

        // All-zero key reload and all-zero plaintext.
        $display("[TB] zero key");
        sendWords(128'h0, 1'b1, 0, 3);
        checkOutput("keyin_zero", aes_keyin, 0);
        sendWords(128'h0, 1'b0, 0, 3);
        drainOutputs(0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
